// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - digit-serial a - b - bin with start/done handshake (optional ovf via SERIAL_SUB_OVF_EN)
module serial_subtractor #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] d,
    output logic             bout
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int K  = WIDTH / DIGIT;
    localparam int CW = (K > 1) ? $clog2(K) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t               state, state_nx;
    logic [WIDTH-1:0]     sa, sb;
    logic                 br;
    logic [CW-1:0]        cnt;
    logic                 last;
    logic [DIGIT-1:0]     dig;
    logic [DIGIT:0]       chain;
    logic [WIDTH+DIGIT-1:0] dcat;

    assign last = (cnt == CW'(K - 1));
    assign busy = (state != S_IDLE);
    assign done = (state == S_DONE);
    // new digit enters from the MSB side so digit 0 ends up at d[DIGIT-1:0]
    assign dcat = {dig, d};

    // chain[i] is the borrow into bit i of the current digit
    always_comb begin
        chain    = '0;
        dig      = '0;
        chain[0] = br;
        for (int i = 0; i < DIGIT; i++) begin
            dig[i]       = sa[i] ^ sb[i] ^ chain[i];
            chain[i + 1] = (~sa[i] & sb[i]) | (chain[i] & ~(sa[i] ^ sb[i]));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (start) state_nx = S_RUN;
            S_RUN:   if (last) state_nx = S_DONE;
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sa   <= '0;
            sb   <= '0;
            br   <= 1'b0;
            cnt  <= '0;
            d    <= '0;
            bout <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            ovf  <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        sa  <= a;
                        sb  <= b;
                        br  <= bin;
                        cnt <= '0;
                        d   <= '0;
                    end
                end
                S_RUN: begin
                    sa  <= sa >> DIGIT;
                    sb  <= sb >> DIGIT;
                    br  <= chain[DIGIT];
                    cnt <= cnt + CW'(1);
                    d   <= dcat[WIDTH+DIGIT-1:DIGIT];
                    if (last) begin
                        bout <= chain[DIGIT];
`ifdef SERIAL_SUB_OVF_EN
                        // signed overflow: borrow into MSB differs from borrow out of MSB
                        ovf  <= chain[DIGIT-1] ^ chain[DIGIT];
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
